bus_target: RTL and testbench

- Responder end of the multiplexed 16-bit address/data system bus. The initiator side issues ALE / RDN / WRN cycles; this block answers them.
- Decodes and latches the 20-bit address {asbus, adbus}, checks the memory/IO space and address window, and converts each selected bus cycle into a single-request backend access (SRAM, peripheral register file).
- Drives READY low as a wait-state generator until backend data is ready, and drives read data onto adbus during the data phase.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/bus_addr_decode.sv | 25 ++
 rtl/bus_target.sv | 152 +++++++++++++++
 tb/tb_bus_target.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings and widths for the multiplexed address/data system bus.
// Used by both the responder (bus_target) and the initiator side.
package bus_pkg;

  localparam int AD_W   = 16;
  localparam int AS_W   = 4;
  localparam int ADDR_W = AD_W + AS_W;

  // Strobes (rdN, wrN, denN) are active when they equal this level.
  localparam logic RW_ACTIVE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_REQ,
    ST_WAIT,
    ST_DATA
  } bus_state_t;

  typedef enum logic [1:0] {
    BE_NONE = 2'b00,
    BE_LO   = 2'b01,
    BE_HI   = 2'b10,
    BE_WORD = 2'b11
  } bus_be_t;

  // {A0, bheN} -> byte lanes; an odd address with BHE inactive selects nothing.
  function automatic bus_be_t be_decode(input logic a0, input logic bhe_n);
    case ({a0, bhe_n})
      2'b00:   return BE_WORD;
      2'b01:   return BE_LO;
      2'b10:   return BE_HI;
      default: return BE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational window/space decode of a latched 20-bit bus address into
// select, byte enables and word address.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter logic              SPACE_IO = 1'b0,
  parameter logic [ADDR_W-1:0] BASE     = 20'h00000,
  parameter logic [ADDR_W-1:0] MASK     = 20'hF0000
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              bhe_n,
  input  logic              m_io_n,
  output logic              sel,
  output logic [1:0]        be,
  output logic [ADDR_W-2:0] word_addr
);

  bus_be_t be_dec;

  assign be_dec    = be_decode(addr[0], bhe_n);
  assign be        = be_dec;
  assign word_addr = addr[ADDR_W-1:1];
  assign sel       = (m_io_n == ~SPACE_IO) && ((addr & MASK) == BASE) && (be_dec != BE_NONE);

endmodule

// File: rtl/bus_target.sv
// Responder for the multiplexed ALE/RDN/WRN bus: latches and decodes the address,
// turns each selected cycle into one backend request and holds READY low until done.
module bus_target
  import bus_pkg::*;
#(
  parameter logic              SPACE_IO = 1'b0,
  parameter logic [ADDR_W-1:0] BASE     = 20'h00000,
  parameter logic [ADDR_W-1:0] MASK     = 20'hF0000,
  parameter int                MIN_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ale,
  input  logic              m_ioN,
  input  logic              dt_rN,
  input  logic              bheN,
  input  logic              denN,
  input  logic              rdN,
  input  logic              wrN,
  inout  wire  [AD_W-1:0]   adbus,
  input  logic [AS_W-1:0]   asbus,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [AD_W-1:0]   mem_wdata,
  input  logic [AD_W-1:0]   mem_rdata,
  input  logic              mem_ack
);

  bus_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              bhe_n_reg;
  logic              m_io_n_reg;
  logic              ale_d_reg;
  logic [3:0]        wait_cnt_reg;
  logic              ack_seen_reg;
  logic [AD_W-1:0]   rdata_reg;
  logic              ready_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-2:0] mem_addr_reg;
  logic [1:0]        mem_be_reg;
  logic [AD_W-1:0]   mem_wdata_reg;

  logic              dec_sel;
  logic [1:0]        dec_be;
  logic [ADDR_W-2:0] dec_word_addr;
  logic              strobe_rd, strobe_wr, ack_now, wait_done, ad_oe;

  bus_addr_decode #(
    .SPACE_IO(SPACE_IO),
    .BASE    (BASE),
    .MASK    (MASK)
  ) u_decode (
    .addr     (addr_reg),
    .bhe_n    (bhe_n_reg),
    .m_io_n   (m_io_n_reg),
    .sel      (dec_sel),
    .be       (dec_be),
    .word_addr(dec_word_addr)
  );

  // rdN wins over wrN when both are low.
  assign strobe_rd = (rdN == RW_ACTIVE);
  assign strobe_wr = (wrN == RW_ACTIVE) && (denN == RW_ACTIVE);
  assign ack_now   = mem_ack && mem_req_reg;
  assign wait_done = (ack_seen_reg || ack_now) && (wait_cnt_reg == 4'd0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!ale && ale_d_reg && dec_sel) state_next = ST_ARMED;
      ST_ARMED: begin
        if (strobe_rd || strobe_wr) state_next = ST_REQ;
        else if (ale)               state_next = ST_IDLE;
      end
      ST_REQ, ST_WAIT: state_next = wait_done ? ST_DATA : ST_WAIT;
      ST_DATA:  if ((mem_we_reg ? wrN : rdN) != RW_ACTIVE) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      bhe_n_reg     <= 1'b1;
      m_io_n_reg    <= 1'b1;
      ale_d_reg     <= 1'b0;
      wait_cnt_reg  <= 4'd0;
      ack_seen_reg  <= 1'b0;
      rdata_reg     <= '0;
      ready_reg     <= 1'b1;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= 2'b00;
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      ale_d_reg <= ale;
      if (ale) begin
        addr_reg   <= {asbus, adbus};
        bhe_n_reg  <= bheN;
        m_io_n_reg <= m_ioN;
      end
      case (state_reg)
        ST_IDLE: begin
          if (state_next == ST_ARMED) begin
            mem_addr_reg <= dec_word_addr;
            mem_be_reg   <= dec_be;
          end
        end
        ST_ARMED: begin
          if (state_next == ST_REQ) begin
            mem_we_reg   <= !strobe_rd;
            if (!strobe_rd) mem_wdata_reg <= adbus;
            mem_req_reg  <= 1'b1;
            ready_reg    <= 1'b0;
            wait_cnt_reg <= 4'(MIN_WAIT);
            ack_seen_reg <= 1'b0;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (wait_cnt_reg != 4'd0) wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (ack_now) begin
            mem_req_reg  <= 1'b0;
            ack_seen_reg <= 1'b1;
            if (!mem_we_reg) rdata_reg <= mem_rdata;
          end
          if (state_next == ST_DATA) ready_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Combinational enable so the bus is released in the same cycle rdN/denN rise.
  assign ad_oe = (state_reg == ST_DATA) && !mem_we_reg && (rdN == RW_ACTIVE) &&
                 (denN == RW_ACTIVE) && (dt_rN == 1'b0);
  assign adbus = ad_oe ? rdata_reg : {AD_W{1'bz}};

  assign ready     = ready_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_bus_target.sv
// Two bus_target responders share one bus (window 0x0xxxx with no minimum wait,
// window 0x2xxxx with three); a scoreboard checks backend requests and READY/read data.
module tb_bus_target;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ale, m_ioN, dt_rN, bheN, denN, rdN, wrN;
  logic [3:0]  asbus;
  logic [15:0] ad_drv;
  logic        ad_oe;
  wire  [15:0] adbus;
  assign adbus = ad_oe ? ad_drv : 16'hzzzz;

  logic [1:0]  ready_v, req_v;
  logic [15:0] bk_rdata;
  int          bk_delay;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    int          tgt;
    logic        we;
    logic [18:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          req_len;   // -1: not checked
  } req_t;

  typedef struct {
    int          tgt;
    logic        rd;
    logic [15:0] data;
    int          low_len;   // -1: not checked
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int who);
    n_vec++;
    n_err++;
    $display("FAIL %s: dut%0d produced an event with no expected entry, expected none", name, who);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_t
    localparam logic [19:0] BASE_P = (gi == 0) ? 20'h00000 : 20'h20000;
    localparam int          MW_P   = (gi == 0) ? 0 : 3;

    logic        ready, mem_req, mem_we, mem_ack;
    logic [18:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;

    bus_target #(
      .SPACE_IO(1'b0),
      .BASE    (BASE_P),
      .MASK    (20'hF0000),
      .MIN_WAIT(MW_P)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .ale      (ale),
      .m_ioN    (m_ioN),
      .dt_rN    (dt_rN),
      .bheN     (bheN),
      .denN     (denN),
      .rdN      (rdN),
      .wrN      (wrN),
      .adbus    (adbus),
      .asbus    (asbus),
      .ready    (ready),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_be   (mem_be),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack)
    );

    assign ready_v[gi] = ready;
    assign req_v[gi]   = mem_req;

    // Backend: acks bk_delay cycles after the request becomes visible.
    initial begin
      int cnt;
      bit done;
      cnt = 0;
      done = 0;
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (!mem_req) begin
          cnt = 0;
          done = 0;
        end else if (!done) begin
          if (cnt >= bk_delay) begin
            mem_ack = 1'b1;
            mem_rdata = bk_rdata;
            done = 1;
          end else begin
            cnt++;
          end
        end
      end
    end

    // Monitor: request contents/length and READY low length/read data.
    initial begin
      int hcnt, lcnt, cur_len;
      req_t r;
      rsp_t s;
      hcnt = 0;
      lcnt = 0;
      cur_len = -1;
      forever begin
        @(negedge clk);
        if (mem_req) begin
          if (hcnt == 0) begin
            if (req_q.size() == 0) begin
              note_fail("req_unexpected", gi);
              cur_len = -1;
            end else begin
              r = req_q.pop_front();
              chk("req_target", gi, r.tgt);
              chk("mem_addr", {13'd0, mem_addr}, {13'd0, r.addr});
              chk("mem_be", {30'd0, mem_be}, {30'd0, r.be});
              chk("mem_we", {31'd0, mem_we}, {31'd0, r.we});
              if (r.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, r.wdata});
              cur_len = r.req_len;
            end
          end
          hcnt++;
        end else if (hcnt > 0) begin
          if (cur_len >= 0) chk("req_len", hcnt, cur_len);
          hcnt = 0;
        end

        if (!ready) begin
          lcnt++;
        end else if (lcnt > 0) begin
          if (rsp_q.size() == 0) begin
            note_fail("ready_unexpected", gi);
          end else begin
            s = rsp_q.pop_front();
            chk("ready_target", gi, s.tgt);
            if (s.low_len >= 0) begin
              chk("ready_low_len", lcnt, s.low_len);
              if (s.rd) chk("rd_data", {16'd0, adbus}, {16'd0, s.data});
            end
          end
          lcnt = 0;
        end
      end
    end
  end

  // Reference model: which responder owns a cycle and how long it should take.
  function automatic int model_tgt(input logic [19:0] a, input logic bhe, input logic mio);
    if (!mio) return -1;
    if (a[0] && bhe) return -1;
    if (a[19:16] == 4'h0) return 0;
    if (a[19:16] == 4'h2) return 1;
    return -1;
  endfunction

  function automatic int model_low(input int tgt, input int d);
    int mw;
    mw = (tgt == 1) ? 3 : 0;
    return ((mw > d) ? mw : d) + 1;
  endfunction

  task automatic push_exp(input int t, input logic [19:0] a, input logic bhe, input logic we,
                          input logic [15:0] wd, input logic [15:0] rd, input int d);
    req_t r;
    rsp_t s;
    r.tgt = t;
    r.we = we;
    r.addr = a[19:1];
    r.be = {~bhe, ~a[0]};
    r.wdata = wd;
    r.req_len = d + 1;
    s.tgt = t;
    s.rd = !we;
    s.data = rd;
    s.low_len = model_low(t, d);
    req_q.push_back(r);
    rsp_q.push_back(s);
  endtask

  task automatic addr_phase(input logic [19:0] a, input logic bhe, input logic mio);
    @(negedge clk);
    ale = 1'b1;
    asbus = a[19:16];
    ad_drv = a[15:0];
    ad_oe = 1'b1;
    bheN = bhe;
    m_ioN = mio;
    @(negedge clk);
    ale = 1'b0;
    ad_oe = 1'b0;
  endtask

  task automatic data_phase(input bit sel, input logic we, input logic [15:0] wd,
                            input logic [15:0] rd);
    bit seen_low, ok, quiet;
    @(negedge clk);
    denN = 1'b0;
    if (we) begin
      dt_rN = 1'b1;
      ad_drv = wd;
      ad_oe = 1'b1;
      wrN = 1'b0;
    end else begin
      dt_rN = 1'b0;
      rdN = 1'b0;
    end
    if (sel) begin
      seen_low = 0;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (ready_v != 2'b11) seen_low = 1;
        else if (seen_low) ok = 1;
      end
      chk("ready_handshake", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      rdN = 1'b1;
      wrN = 1'b1;
      denN = 1'b1;
      ad_oe = 1'b0;
      if (!we) begin
        #1;
        n_vec++;
        if (adbus === rd) begin
          n_err++;
          $display("FAIL rd_release: got %h still driven, expected bus released", adbus);
        end
      end
    end else begin
      quiet = 1;
      repeat (3) begin
        @(negedge clk);
        if (ready_v != 2'b11 || req_v != 2'b00) quiet = 0;
      end
      chk("unselected_quiet", {31'd0, quiet}, 32'd1);
      rdN = 1'b1;
      wrN = 1'b1;
      denN = 1'b1;
      ad_oe = 1'b0;
    end
    @(negedge clk);
  endtask

  int txn_no = 0;

  task automatic do_cycle(input logic [19:0] a, input logic bhe, input logic mio, input logic we,
                          input logic [15:0] wd, input logic [15:0] rd, input int d);
    int t;
    t = model_tgt(a, bhe, mio);
    bk_delay = d;
    bk_rdata = rd;
    addr_phase(a, bhe, mio);
    if (t >= 0) push_exp(t, a, bhe, we, wd, rd, d);
    data_phase(t >= 0, we, wd, rd);
    $display("txn %0d: %s addr=%h bheN=%b m_ioN=%b wdata=%h rdata=%h ack_delay=%0d target=%0d",
             txn_no, we ? "WR" : "RD", a, bhe, mio, wd, rd, d, t);
    txn_no++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a;
    logic [15:0] rd;
    reset = 1'b0;
    ale = 1'b0;
    m_ioN = 1'b1;
    dt_rN = 1'b1;
    bheN = 1'b1;
    denN = 1'b1;
    rdN = 1'b1;
    wrN = 1'b1;
    asbus = 4'h0;
    ad_drv = 16'h0000;
    ad_oe = 1'b0;
    bk_delay = 0;
    bk_rdata = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, ready_v}, 32'd3);
    chk("rst_mem_req", {30'd0, req_v}, 32'd0);
    chk("rst_mem_addr", {13'd0, g_t[0].mem_addr}, 32'd0);
    chk("rst_mem_be", {30'd0, g_t[0].mem_be}, 32'd0);
    chk("rst_mem_we", {31'd0, g_t[1].mem_we}, 32'd0);
    chk("rst_mem_wdata", {16'd0, g_t[1].mem_wdata}, 32'd0);
    reset = 1'b1;

    // Directed cycles
    do_cycle(20'h01234, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 1);
    do_cycle(20'h00005, 1'b0, 1'b1, 1'b1, 16'hA500, 16'h0001, 2);
    do_cycle(20'h10000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 0);
    do_cycle(20'h00100, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h2222, 0);
    do_cycle(20'h20010, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h3C3C, 0);
    do_cycle(20'h20012, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7E7E, 6);
    do_cycle(20'h00003, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h4444, 0);
    do_cycle(20'h00040, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9A9A, 0);
    do_cycle(20'h00042, 1'b1, 1'b1, 1'b1, 16'h00C3, 16'h0001, 0);

    // ALE in ARMED restarts the address phase: only the second address is serviced
    bk_delay = 1;
    bk_rdata = 16'h5151;
    addr_phase(20'h00400, 1'b0, 1'b1);
    addr_phase(20'h20402, 1'b1, 1'b1);
    push_exp(1, 20'h20402, 1'b1, 1'b0, 16'h0000, 16'h5151, 1);
    data_phase(1'b1, 1'b0, 16'h0000, 16'h5151);
    $display("txn %0d: RD addr=20402 after aborted address 00400 target=1", txn_no);
    txn_no++;

    // Reset pulsed while the backend request is outstanding
    bk_delay = 30;
    bk_rdata = 16'h6666;
    addr_phase(20'h20040, 1'b0, 1'b1);
    begin
      req_t r;
      rsp_t s;
      r.tgt = 1; r.we = 1'b0; r.addr = 19'h10020; r.be = 2'b11; r.wdata = 16'h0; r.req_len = -1;
      s.tgt = 1; s.rd = 1'b1; s.data = 16'h0; s.low_len = -1;
      req_q.push_back(r);
      rsp_q.push_back(s);
    end
    @(negedge clk);
    denN = 1'b0;
    dt_rN = 1'b0;
    rdN = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_req", {31'd0, req_v[1]}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", {30'd0, req_v}, 32'd0);
    chk("midrst_ready", {30'd0, ready_v}, 32'd3);
    chk("midrst_mem_addr", {13'd0, g_t[1].mem_addr}, 32'd0);
    @(negedge clk);
    rdN = 1'b1;
    denN = 1'b1;
    reset = 1'b1;
    $display("txn %0d: RD addr=20040 interrupted by reset target=1", txn_no);
    txn_no++;
    do_cycle(20'h20044, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0F0F, 2);

    // Randomized cycles
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a[19:16] = 4'h0;
        1:       a[19:16] = 4'h2;
        2:       a[19:16] = 4'h1;
        default: a[19:16] = 4'h0;
      endcase
      a[15:0] = 16'($urandom);
      rd = 16'($urandom_range(1, 65535));
      do_cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               16'($urandom), rd, $urandom_range(0, 7));
    end

    repeat (4) @(negedge clk);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
